// File: rtl/msg_stream_buffer.sv
// Byte message buffer between a STB/ACK UART stream and FIFO-style register access.
// Two FWFT FIFOs (RX: stream->OPB, TX: OPB->stream) with counts, flush, sticky errors and RX message count.
module msg_stream_buffer #(
  parameter int unsigned     DW          = 8,
  parameter int unsigned     RX_AW       = 4,
  parameter int unsigned     TX_AW       = 4,
  parameter int unsigned     TX_AFULL_TH = 12,
  parameter logic [DW-1:0]   EOM_CHAR    = 8'h0D
) (
  input  logic              OPB_CLK,
  input  logic              OPB_RST,
  input  logic [DW-1:0]     DATA_STREAM_OUT,
  input  logic              DATA_STREAM_OUT_STB,
  output logic              DATA_STREAM_OUT_ACK,
  output logic [DW-1:0]     DATA_STREAM_IN,
  output logic              DATA_STREAM_IN_STB,
  input  logic              DATA_STREAM_IN_ACK,
  input  logic              RX_FIFO_RD,
  output logic [DW-1:0]     RX_FIFO_DATA,
  output logic              RX_FIFO_EMPTY,
  output logic              RX_FIFO_FULL,
  output logic [RX_AW:0]    RX_FIFO_COUNT,
  output logic [RX_AW:0]    RX_MSG_COUNT,
  output logic              RX_MSG_AVAIL,
  input  logic              RX_FIFO_FLUSH,
  input  logic              TX_FIFO_WR,
  input  logic [DW-1:0]     TX_FIFO_DATA,
  output logic              TX_FIFO_FULL,
  output logic              TX_FIFO_AFULL,
  output logic [TX_AW:0]    TX_FIFO_COUNT,
  input  logic              TX_FIFO_FLUSH,
  input  logic              STATUS_CLR,
  output logic              RX_UNDERFLOW,
  output logic              TX_OVERFLOW
);

  localparam logic [TX_AW:0] TX_TH = (TX_AW+1)'(TX_AFULL_TH);

  logic [DW-1:0] rx_mem [0:(1<<RX_AW)-1];
  logic [DW-1:0] tx_mem [0:(1<<TX_AW)-1];
  logic [RX_AW:0] rx_wptr, rx_rptr;
  logic [TX_AW:0] tx_wptr, tx_rptr;
  logic           ack_q;
  logic           rx_empty, rx_full, rx_wr, rx_rd, msg_inc, msg_dec;
  logic           tx_empty, tx_full, tx_wr, tx_rd;

  always_comb begin
    rx_empty = (rx_wptr == rx_rptr);
    rx_full  = (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]) && (rx_wptr[RX_AW] != rx_rptr[RX_AW]);
    tx_empty = (tx_wptr == tx_rptr);
    tx_full  = (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]) && (tx_wptr[TX_AW] != tx_rptr[TX_AW]);
    // Flush wins over any same-cycle transfer; an ACKed byte in a flush cycle is dropped.
    rx_wr    = DATA_STREAM_OUT_STB & ack_q & ~RX_FIFO_FLUSH;
    rx_rd    = RX_FIFO_RD & ~rx_empty & ~RX_FIFO_FLUSH;
    tx_wr    = TX_FIFO_WR & ~tx_full & ~TX_FIFO_FLUSH;
    tx_rd    = DATA_STREAM_IN_ACK & ~tx_empty & ~TX_FIFO_FLUSH;
    msg_inc  = rx_wr & (DATA_STREAM_OUT == EOM_CHAR);
    msg_dec  = rx_rd & (RX_FIFO_DATA == EOM_CHAR);
  end

  always_ff @(posedge OPB_CLK) begin
    if (rx_wr) rx_mem[rx_wptr[RX_AW-1:0]] <= DATA_STREAM_OUT;
    if (tx_wr) tx_mem[tx_wptr[TX_AW-1:0]] <= TX_FIFO_DATA;
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      ack_q        <= 1'b0;
      rx_wptr      <= '0;
      rx_rptr      <= '0;
      RX_MSG_COUNT <= '0;
    end else begin
      ack_q <= DATA_STREAM_OUT_STB & ~rx_full & ~ack_q;
      if (RX_FIFO_FLUSH) begin
        rx_wptr      <= '0;
        rx_rptr      <= '0;
        RX_MSG_COUNT <= '0;
      end else begin
        if (rx_wr) rx_wptr <= rx_wptr + 1'b1;
        if (rx_rd) rx_rptr <= rx_rptr + 1'b1;
        case ({msg_inc, msg_dec})
          2'b10:   RX_MSG_COUNT <= RX_MSG_COUNT + 1'b1;
          2'b01:   RX_MSG_COUNT <= RX_MSG_COUNT - 1'b1;
          default: RX_MSG_COUNT <= RX_MSG_COUNT;
        endcase
      end
    end
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else if (TX_FIFO_FLUSH) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_wr) tx_wptr <= tx_wptr + 1'b1;
      if (tx_rd) tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // Error flags are set-dominant over STATUS_CLR.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      RX_UNDERFLOW <= 1'b0;
      TX_OVERFLOW  <= 1'b0;
    end else begin
      RX_UNDERFLOW <= (RX_FIFO_RD & rx_empty) | (RX_UNDERFLOW & ~STATUS_CLR);
      TX_OVERFLOW  <= (TX_FIFO_WR & tx_full)  | (TX_OVERFLOW  & ~STATUS_CLR);
    end
  end

  always_comb begin
    DATA_STREAM_OUT_ACK = ack_q;
    RX_FIFO_DATA        = rx_mem[rx_rptr[RX_AW-1:0]];
    RX_FIFO_EMPTY       = rx_empty;
    RX_FIFO_FULL        = rx_full;
    RX_FIFO_COUNT       = rx_wptr - rx_rptr;
    RX_MSG_AVAIL        = (RX_MSG_COUNT != '0);
    DATA_STREAM_IN      = tx_mem[tx_rptr[TX_AW-1:0]];
    DATA_STREAM_IN_STB  = ~tx_empty;
    TX_FIFO_FULL        = tx_full;
    TX_FIFO_COUNT       = tx_wptr - tx_rptr;
    TX_FIFO_AFULL       = (TX_FIFO_COUNT >= TX_TH);
  end

endmodule
